comm_fpga_epp_param: RTL

- Next-generation EPP-to-channel bridge. Converts host EPP address and data strobes, clocked on eppClk_in, into a parametrised channel-address and byte-pipe interface.
- Added over the previous generation:
  - parametrised channel-address width and synchroniser depth;
  - host readback of the channel address;
  - a registered h2f data path;
  - an asynchronous active-low reset;
  - an optional handshake timeout.
- Sits between the board EPP pins and the application channel mux.

---
 rtl/comm_fpga_pkg.sv | 18 +
 rtl/epp_sync.sv | 29 ++
 rtl/comm_fpga_epp_param.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/comm_fpga_pkg.sv
// comm_fpga_pkg.sv - shared constants for the EPP-to-channel bridge.
// Holds FSM state codes, the timeout read byte and the synchroniser reset level.
package comm_fpga_pkg;

    localparam logic [2:0] S_IDLE            = 3'd0;
    localparam logic [2:0] S_ADDR_WRITE_WAIT = 3'd1;
    localparam logic [2:0] S_ADDR_READ_WAIT  = 3'd2;
    localparam logic [2:0] S_DATA_WRITE_EXEC = 3'd3;
    localparam logic [2:0] S_DATA_WRITE_WAIT = 3'd4;
    localparam logic [2:0] S_DATA_READ_EXEC  = 3'd5;
    localparam logic [2:0] S_DATA_READ_WAIT  = 3'd6;

    localparam logic [7:0] TIMEOUT_RD_BYTE = 8'hFF;

    // EPP strobes are active low, so the inactive level is 1.
    localparam logic SYNC_RST_VAL = 1'b1;

endpackage

// File: rtl/epp_sync.sv
// epp_sync.sv - STAGES-deep synchroniser for asynchronous EPP inputs.
// Resets to the inactive (high) level so no strobe is seen during reset.
module epp_sync
    import comm_fpga_pkg::*;
#(
    parameter int STAGES = 2
)(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{SYNC_RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/comm_fpga_epp_param.sv
// comm_fpga_epp_param.sv - EPP host bridge to channel address and byte pipes.
// Define EPP_TIMEOUT_EN to build the EXEC-state handshake timeout.
module comm_fpga_epp_param
    import comm_fpga_pkg::*;
#(
    parameter int CHAN_WIDTH     = 7,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                  eppClk_in,
    input  logic                  eppResetN_in,
    inout  wire  [7:0]            eppData_io,
    input  logic                  eppAddrStb_in,
    input  logic                  eppDataStb_in,
    input  logic                  eppWrite_in,
    output logic                  eppWait_out,
    output logic [CHAN_WIDTH-1:0] chanAddr_out,
    output logic [7:0]            h2fData_out,
    output logic                  h2fValid_out,
    input  logic                  h2fReady_in,
    input  logic [7:0]            f2hData_in,
    input  logic                  f2hValid_in,
    output logic                  f2hReady_out,
    output logic                  timeout_out
);

    // Elaboration marker for out-of-range parameters.
    if (CHAN_WIDTH < 1 || CHAN_WIDTH > 8 ||
        SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badParams
    end

    logic       addrStb;
    logic       dataStb;
    logic       hostRead;
    logic [2:0] state;
    logic [7:0] rdData;
    logic       execWr;
    logic       execRd;
    logic       handshake;
    logic       abort;
    logic       toHit;

    epp_sync #(.STAGES(SYNC_STAGES)) u_addrSync (
        .clk   (eppClk_in),
        .rst_n (eppResetN_in),
        .d     (eppAddrStb_in),
        .q     (addrStb)
    );

    epp_sync #(.STAGES(SYNC_STAGES)) u_dataSync (
        .clk   (eppClk_in),
        .rst_n (eppResetN_in),
        .d     (eppDataStb_in),
        .q     (dataStb)
    );

    epp_sync #(.STAGES(SYNC_STAGES)) u_writeSync (
        .clk   (eppClk_in),
        .rst_n (eppResetN_in),
        .d     (eppWrite_in),
        .q     (hostRead)
    );

    // Bus direction follows the raw pin so the host sees data immediately.
    assign eppData_io = eppWrite_in ? rdData : 8'bz;

    assign execWr    = (state == S_DATA_WRITE_EXEC);
    assign execRd    = (state == S_DATA_READ_EXEC);
    assign handshake = (execWr && h2fReady_in) || (execRd && f2hValid_in);
    assign abort     = (execWr || execRd) && !handshake && toHit;

`ifdef EPP_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] toCount;

    assign toHit = (toCount + 16'd1) == TO_LIMIT;

    always_ff @(posedge eppClk_in or negedge eppResetN_in) begin
        if (!eppResetN_in) begin
            toCount     <= '0;
            timeout_out <= 1'b0;
        end else begin
            timeout_out <= abort;
            if (execWr || execRd) begin
                toCount <= toCount + 16'd1;
            end else begin
                toCount <= '0;
            end
        end
    end
`else
    assign toHit       = 1'b0;
    assign timeout_out = 1'b0;
`endif

    always_ff @(posedge eppClk_in or negedge eppResetN_in) begin
        if (!eppResetN_in) begin
            state        <= S_IDLE;
            eppWait_out  <= 1'b0;
            chanAddr_out <= '0;
            h2fData_out  <= 8'h00;
            h2fValid_out <= 1'b0;
            f2hReady_out <= 1'b0;
            rdData       <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    eppWait_out <= 1'b0;
                    if (!addrStb) begin
                        eppWait_out <= 1'b1;
                        if (!hostRead) begin
                            chanAddr_out <= eppData_io[CHAN_WIDTH-1:0];
                            state        <= S_ADDR_WRITE_WAIT;
                        end else begin
                            rdData <= 8'(chanAddr_out);
                            state  <= S_ADDR_READ_WAIT;
                        end
                    end else if (!dataStb) begin
                        if (!hostRead) begin
                            h2fData_out  <= eppData_io;
                            h2fValid_out <= 1'b1;
                            state        <= S_DATA_WRITE_EXEC;
                        end else begin
                            f2hReady_out <= 1'b1;
                            state        <= S_DATA_READ_EXEC;
                        end
                    end
                end
                S_DATA_WRITE_EXEC: begin
                    if (h2fReady_in || abort) begin
                        h2fValid_out <= 1'b0;
                        eppWait_out  <= 1'b1;
                        state        <= S_DATA_WRITE_WAIT;
                    end
                end
                S_DATA_READ_EXEC: begin
                    if (f2hValid_in || abort) begin
                        rdData       <= f2hValid_in ? f2hData_in : TIMEOUT_RD_BYTE;
                        f2hReady_out <= 1'b0;
                        eppWait_out  <= 1'b1;
                        state        <= S_DATA_READ_WAIT;
                    end
                end
                S_ADDR_WRITE_WAIT, S_ADDR_READ_WAIT: begin
                    if (addrStb) begin
                        eppWait_out <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_DATA_WRITE_WAIT, S_DATA_READ_WAIT: begin
                    if (dataStb) begin
                        eppWait_out <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
